// File: rtl/cnn_gap_classifier.sv
// Classifier head: per-channel global average pooling over a pixel-interleaved feature stream,
// followed by NCLS saturating signed class scores and a lowest-index-wins argmax.
module cnn_gap_classifier #(
  parameter int CH   = 4,
  parameter int PIX  = 1024,
  parameter int DW   = 8,
  parameter int NCLS = 4,
  parameter int WW   = 8,
  parameter int SW   = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              feat_valid,
  input  logic [DW-1:0]                     feat_data,
  output logic                              feat_ready,
  input  logic                              w_we,
  input  logic [$clog2(NCLS*CH+NCLS)-1:0]   w_addr,
  input  logic [SW-1:0]                     w_data,
  output logic [$clog2(NCLS)-1:0]           class_out,
  output logic [SW-1:0]                     final_score,
  output logic                              done,
  output logic                              busy,
  output logic [2:0]                        debug_state
);

  localparam int PW  = $clog2(PIX);
  localparam int PCW = (PW > 0) ? PW : 1;
  localparam int AW  = DW + PW;
  localparam int CW  = (CH > 1) ? $clog2(CH) : 1;
  localparam int KW  = $clog2(NCLS);
  localparam int NW  = NCLS * CH;
  localparam int WIX = (NW > 1) ? $clog2(NW) : 1;
  localparam int WAW = $clog2(NW + NCLS);
  // Wide enough for bias plus CH full products without wrapping before saturation.
  localparam int MW  = SW + WW + DW + CW + 2;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCUM  = 3'd1;
  localparam logic [2:0] S_POOL   = 3'd2;
  localparam logic [2:0] S_SCORE  = 3'd3;
  localparam logic [2:0] S_ARGMAX = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  function automatic logic [SW-1:0] sat_score(input logic signed [MW-1:0] v);
    logic signed [MW-1:0] hi;
    logic signed [MW-1:0] lo;
    hi = {{(MW-SW+1){1'b0}}, {(SW-1){1'b1}}};
    lo = {{(MW-SW+1){1'b1}}, {(SW-1){1'b0}}};
    if (v > hi) begin
      return {1'b0, {(SW-1){1'b1}}};
    end else if (v < lo) begin
      return {1'b1, {(SW-1){1'b0}}};
    end else begin
      return v[SW-1:0];
    end
  endfunction

  logic [2:0]             state_q, state_d;
  logic [AW-1:0]          acc_q [CH];
  logic [AW-1:0]          acc_d [CH];
  logic [DW-1:0]          avg_q [CH];
  logic [DW-1:0]          avg_d [CH];
  logic [CW-1:0]          chan_q, chan_d;
  logic [PCW-1:0]         pix_q, pix_d;
  logic [KW-1:0]          k_q, k_d;
  logic [CW-1:0]          c_q, c_d;
  logic [KW-1:0]          a_q, a_d;
  logic signed [MW-1:0]   mac_q, mac_d;
  logic [SW-1:0]          score_q [NCLS];
  logic [SW-1:0]          score_d [NCLS];
  logic signed [SW-1:0]   best_q, best_d;
  logic [KW-1:0]          best_idx_q, best_idx_d;
  logic [KW-1:0]          class_q, class_d;
  logic [SW-1:0]          final_q, final_d;
  logic                   done_q, done_d;
  logic [WW-1:0]          weight_q [NW];
  logic [WW-1:0]          weight_d [NW];
  logic [SW-1:0]          bias_q [NCLS];
  logic [SW-1:0]          bias_d [NCLS];

  logic [WIX-1:0]         widx_s;
  logic [WW-1:0]          w_sel_s;
  logic signed [MW-1:0]   w_ext_s, a_ext_s, b_ext_s, prod_s, mac_sum_s;
  logic signed [SW-1:0]   cand_s;
  logic                   last_word_s;
  logic [KW-1:0]          bidx_s;

  // Next-state, datapath and weight-store update.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    avg_d      = avg_q;
    chan_d     = chan_q;
    pix_d      = pix_q;
    k_d        = k_q;
    c_d        = c_q;
    a_d        = a_q;
    mac_d      = mac_q;
    score_d    = score_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    class_d    = class_q;
    final_d    = final_q;
    done_d     = 1'b0;
    weight_d   = weight_q;
    bias_d     = bias_q;

    last_word_s = (chan_q == CW'(CH-1)) && (pix_q == PCW'(PIX-1));
    widx_s      = WIX'(k_q) * WIX'(CH) + WIX'(c_q);
    w_sel_s     = weight_q[widx_s];
    w_ext_s     = {{(MW-WW){w_sel_s[WW-1]}}, w_sel_s};
    a_ext_s     = {{(MW-DW){1'b0}}, avg_q[c_q]};
    b_ext_s     = {{(MW-SW){bias_q[k_q][SW-1]}}, bias_q[k_q]};
    prod_s      = w_ext_s * a_ext_s;
    mac_sum_s   = ((c_q == CW'(0)) ? b_ext_s : mac_q) + prod_s;
    cand_s      = $signed(score_q[a_q]);
    bidx_s      = KW'(w_addr - WAW'(NW));

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          chan_d  = '0;
          pix_d   = '0;
          for (int i = 0; i < CH; i++) acc_d[i] = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (feat_valid) begin
          acc_d[chan_q] = acc_q[chan_q] + AW'(feat_data);
          if (chan_q == CW'(CH-1)) begin
            chan_d = '0;
            pix_d  = pix_q + PCW'(1);
          end else begin
            chan_d = chan_q + CW'(1);
          end
          if (last_word_s) begin
            state_d = S_POOL;
          end else begin
            state_d = S_ACCUM;
          end
        end else begin
          state_d = S_ACCUM;
        end
      end
      S_POOL: begin
        for (int i = 0; i < CH; i++) avg_d[i] = DW'(acc_q[i] >> PW);
        k_d     = '0;
        c_d     = '0;
        state_d = S_SCORE;
      end
      S_SCORE: begin
        mac_d = mac_sum_s;
        if (c_q == CW'(CH-1)) begin
          score_d[k_q] = sat_score(mac_sum_s);
          c_d          = '0;
          if (k_q == KW'(NCLS-1)) begin
            k_d     = '0;
            a_d     = '0;
            state_d = S_ARGMAX;
          end else begin
            k_d = k_q + KW'(1);
          end
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      S_ARGMAX: begin
        // Strict compare keeps the earlier index on a tie.
        if ((a_q == KW'(0)) || (cand_s > best_q)) begin
          best_d     = cand_s;
          best_idx_d = a_q;
        end else begin
          best_d     = best_q;
          best_idx_d = best_idx_q;
        end
        if (a_q == KW'(NCLS-1)) begin
          class_d = best_idx_d;
          final_d = best_d;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          a_d = a_q + KW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_we && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
      if (w_addr < WAW'(NW)) begin
        weight_d[w_addr[WIX-1:0]] = w_data[WW-1:0];
      end else if (w_addr < WAW'(NW + NCLS)) begin
        bias_d[bidx_s] = w_data;
      end else begin
        bias_d = bias_q;
      end
    end else begin
      weight_d = weight_q;
    end
  end

  // State and storage registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      chan_q     <= '0;
      pix_q      <= '0;
      k_q        <= '0;
      c_q        <= '0;
      a_q        <= '0;
      mac_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      class_q    <= '0;
      final_q    <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        acc_q[i] <= '0;
        avg_q[i] <= '0;
      end
      for (int i = 0; i < NCLS; i++) begin
        score_q[i] <= '0;
        bias_q[i]  <= '0;
      end
      for (int i = 0; i < NW; i++) weight_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      avg_q      <= avg_d;
      chan_q     <= chan_d;
      pix_q      <= pix_d;
      k_q        <= k_d;
      c_q        <= c_d;
      a_q        <= a_d;
      mac_q      <= mac_d;
      score_q    <= score_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
      class_q    <= class_d;
      final_q    <= final_d;
      done_q     <= done_d;
      weight_q   <= weight_d;
      bias_q     <= bias_d;
    end
  end

  assign feat_ready  = (state_q == S_ACCUM);
  assign busy        = (state_q != S_IDLE);
  assign debug_state = state_q;
  assign class_out   = class_q;
  assign final_score = final_q;
  assign done        = done_q;

endmodule

// File: tb/tb_cnn_gap_classifier.sv
// Directed bench for cnn_gap_classifier with CH=4, PIX=16, NCLS=4 and hand-computed scores.
module tb_cnn_gap_classifier;
  localparam int CH = 4, PIX = 16, DW = 8, NCLS = 4, WW = 8, SW = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1, start = 1'b0, feat_valid = 1'b0, w_we = 1'b0;
  logic [7:0]  feat_data = 8'd0;
  logic [4:0]  w_addr = 5'd0;
  logic [15:0] w_data = 16'd0;
  logic        feat_ready, done, busy;
  logic [1:0]  class_out;
  logic [15:0] final_score;
  logic [2:0]  debug_state;

  int checks = 0, passed = 0;
  int cls, score, lat;
  logic [2:0] st1, st_pool;
  logic done_after;

  cnn_gap_classifier #(.CH(CH), .PIX(PIX), .DW(DW), .NCLS(NCLS), .WW(WW), .SW(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .feat_valid(feat_valid), .feat_data(feat_data),
    .feat_ready(feat_ready), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .class_out(class_out), .final_score(final_score), .done(done), .busy(busy),
    .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_w(input int a, input logic [15:0] d);
    w_we = 1'b1; w_addr = 5'(a); w_data = d;
    tick();
    w_we = 1'b0;
  endtask

  task automatic set_weights(input logic [15:0] wc [4], input logic [15:0] b [4]);
    for (int k = 0; k < NCLS; k++)
      for (int c = 0; c < CH; c++) write_w(k*CH + c, wc[k]);
    for (int k = 0; k < NCLS; k++) write_w(NCLS*CH + k, b[k]);
  endtask

  task automatic feed(input logic [7:0] val, input bit alt, input bit gaps, input bit extra);
    for (int p = 0; p < PIX; p++)
      for (int c = 0; c < CH; c++) begin
        if (gaps && ($urandom_range(0, 2) == 0)) begin
          feat_valid = 1'b0; feat_data = 8'hEE; start = extra;
          tick();
          start = 1'b0;
        end
        feat_valid = 1'b1;
        feat_data  = alt ? 8'(p % 2) : val;
        tick();
      end
    feat_valid = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] val, input bit alt, input bit gaps, input bit extra);
    start = 1'b1;
    tick();
    start = 1'b0;
    st1 = debug_state;
    feed(val, alt, gaps, extra);
    st_pool = debug_state;
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (extra && lat == 5) begin
        w_we = 1'b1; w_addr = 5'd15; w_data = 16'd0;
      end else begin
        w_we = 1'b0;
      end
      tick();
      lat++;
    end
    w_we = 1'b0;
    cls = class_out;
    score = $signed(final_score);
    tick();
    done_after = done;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    checks++; if (feat_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", feat_ready); else passed++;
    checks++; if (class_out !== 2'd0) $display("FAIL reset_class got %0d want 0", class_out); else passed++;
    checks++; if (final_score !== 16'd0) $display("FAIL reset_score got %0d want 0", final_score); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    checks++; if (debug_state !== 3'd0) $display("FAIL reset_state got %0d want 0", debug_state); else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_ramp;
    set_weights('{16'd0, 16'd1, 16'd2, 16'd3}, '{16'd0, 16'd0, 16'd0, 16'd0});
    run_frame(8'd255, 1'b0, 1'b0, 1'b0);
    checks++; if (st1 !== 3'd1) $display("FAIL ramp_accum_state got %0d want 1", st1); else passed++;
    checks++; if (st_pool !== 3'd2) $display("FAIL ramp_pool_state got %0d want 2", st_pool); else passed++;
    checks++; if (lat !== 22) $display("FAIL ramp_latency got %0d want 22", lat); else passed++;
    checks++; if (cls !== 3) $display("FAIL ramp_class got %0d want 3", cls); else passed++;
    checks++; if (score !== 3060) $display("FAIL ramp_score got %0d want 3060", score); else passed++;
    checks++; if (done_after !== 1'b0) $display("FAIL ramp_done_width got %b want 0", done_after); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL ramp_idle_busy got %b want 0", busy); else passed++;
  endtask

  task automatic test_tie;
    set_weights('{16'd1, 16'd1, 16'd1, 16'd1}, '{16'd0, 16'd0, 16'd0, 16'd0});
    run_frame(8'd10, 1'b0, 1'b0, 1'b0);
    checks++; if (cls !== 0) $display("FAIL tie_class got %0d want 0", cls); else passed++;
    checks++; if (score !== 40) $display("FAIL tie_score got %0d want 40", score); else passed++;
  endtask

  task automatic test_saturate;
    set_weights('{16'd127, 16'd127, 16'd127, 16'd127}, '{16'd0, 16'd0, 16'd0, 16'd0});
    run_frame(8'd255, 1'b0, 1'b0, 1'b0);
    checks++; if (cls !== 0) $display("FAIL sat_hi_class got %0d want 0", cls); else passed++;
    checks++; if (score !== 32767) $display("FAIL sat_hi_score got %0d want 32767", score); else passed++;
    set_weights('{16'hFF80, 16'd0, 16'd0, 16'd0}, '{16'd0, 16'h8000, 16'h8000, 16'h8000});
    run_frame(8'd255, 1'b0, 1'b0, 1'b0);
    checks++; if (cls !== 0) $display("FAIL sat_lo_class got %0d want 0", cls); else passed++;
    checks++; if (score !== -32768) $display("FAIL sat_lo_score got %0d want -32768", score); else passed++;
  endtask

  task automatic test_negative;
    set_weights('{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0}, '{16'd0, 16'd0, 16'd0, 16'hFFFB});
    run_frame(8'd100, 1'b0, 1'b0, 1'b0);
    checks++; if (cls !== 3) $display("FAIL neg_class got %0d want 3", cls); else passed++;
    checks++; if (score !== -5) $display("FAIL neg_score got %0d want -5", score); else passed++;
  endtask

  task automatic test_truncate;
    set_weights('{16'd4, 16'd3, 16'd2, 16'd1}, '{16'd0, 16'd1, 16'd2, 16'd3});
    run_frame(8'd0, 1'b1, 1'b0, 1'b0);
    checks++; if (cls !== 3) $display("FAIL trunc_class got %0d want 3", cls); else passed++;
    checks++; if (score !== 3) $display("FAIL trunc_score got %0d want 3", score); else passed++;
  endtask

  task automatic test_back_to_back;
    set_weights('{16'd0, 16'd1, 16'd2, 16'd3}, '{16'd0, 16'd0, 16'd0, 16'd0});
    run_frame(8'd255, 1'b0, 1'b1, 1'b1);
    checks++; if (cls !== 3) $display("FAIL gap_class got %0d want 3", cls); else passed++;
    checks++; if (score !== 3060) $display("FAIL gap_score got %0d want 3060", score); else passed++;
    checks++; if (lat !== 22) $display("FAIL gap_latency got %0d want 22", lat); else passed++;
    run_frame(8'd255, 1'b0, 1'b0, 1'b0);
    checks++; if (score !== 3060) $display("FAIL dropped_write_score got %0d want 3060", score); else passed++;
    tick(); tick(); tick();
    checks++; if (class_out !== 2'd3) $display("FAIL held_class got %0d want 3", class_out); else passed++;
  endtask

  task automatic test_reset_mid;
    int ndone;
    set_weights('{16'd0, 16'd1, 16'd2, 16'd3}, '{16'd0, 16'd0, 16'd0, 16'd0});
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(8'd255, 1'b0, 1'b0, 1'b0);
    repeat (5) tick();
    checks++; if (debug_state !== 3'd3) $display("FAIL mid_in_score got %0d want 3", debug_state); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (debug_state !== 3'd0) $display("FAIL mid_rst_state got %0d want 0", debug_state); else passed++;
    ndone = 0;
    repeat (30) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    checks++; if (ndone !== 0) $display("FAIL mid_rst_done got %0d want 0", ndone); else passed++;
    run_frame(8'd255, 1'b0, 1'b0, 1'b0);
    checks++; if (score !== 0) $display("FAIL cleared_weights_score got %0d want 0", score); else passed++;
    set_weights('{16'd0, 16'd1, 16'd2, 16'd3}, '{16'd0, 16'd0, 16'd0, 16'd0});
    run_frame(8'd255, 1'b0, 1'b0, 1'b0);
    checks++; if (cls !== 3) $display("FAIL reload_class got %0d want 3", cls); else passed++;
    checks++; if (score !== 3060) $display("FAIL reload_score got %0d want 3060", score); else passed++;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_tie();
    test_saturate();
    test_negative();
    test_truncate();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
